match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 416667, meaning clk cycles per frame tick (25 MHz / 60 Hz); legal range 16..2^20.
REQ-002 Parameter WIN_SCORE, default 15, meaning points needed to win a match; legal range 1..15.
REQ-003 Parameter FREEZE_FRAMES, default 90, meaning frame ticks held after a point before play resumes; legal range 1..255.
REQ-004 Parameter TIMEOUT_CYC, default 64, meaning max clk cycles from phys_en to phys_valid; legal range 8..255.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_btn  input  1  synchronous start request, level; only a 0->1 edge is used.
REQ-008 phys_valid  input  1  one-cycle pulse from the physics engine at end of a frame update.
REQ-009 phys_game_over  input  1  physics engine point flag, sampled only while phys_valid=1.
REQ-010 phys_winner  input  2  point winner (1=P1, 2=P2), sampled only while phys_valid=1.
REQ-011 phys_en  output  1  one-cycle frame-update launch pulse to the physics engine.
REQ-012 play_active  output  1  high while player controls are forwarded to physics; low otherwise.
REQ-013 score_p1, score_p2  output  4 each  current match scores.
REQ-014 match_winner  output  2  0=none, 1=P1, 2=P2; valid in state MATCH_END.
REQ-015 state_o  output  3  IDLE=0, RUN=1, WAIT_VALID=2, FREEZE=3, MATCH_END=4.
REQ-016 fault  output  1  sticky flag: physics timeout occurred.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 continuously from reset, independent of state; tick=1 for one cycle when count==TICK_DIV-1.
REQ-018 start edge = start_btn high now and low in the previous cycle; the edge register resets to 1, so a button held through reset produces no edge.
REQ-019 IDLE: on a start edge, clear both scores, clear match_winner, clear fault, then enter RUN.
REQ-020 RUN: on tick, assert phys_en in the next cycle for exactly one cycle, load the timeout counter with 0, and enter WAIT_VALID in that same next cycle.
REQ-021 WAIT_VALID: ticks are dropped; no phys_en is issued; the timeout counter increments every cycle.
REQ-022 WAIT_VALID and phys_valid with phys_game_over=0: return to RUN.
REQ-023 WAIT_VALID and phys_valid with phys_game_over=1 and phys_winner in {1,2}: increment the winner's score by 1.
REQ-024 After the increment, if the new score equals WIN_SCORE: set match_winner to phys_winner and enter MATCH_END; otherwise load the freeze counter with FREEZE_FRAMES and enter FREEZE.
REQ-025 phys_game_over=1 with phys_winner in {0,3}: no score change; return to RUN.
REQ-026 Scores SHALL never exceed WIN_SCORE; an increment is never applied in MATCH_END.
REQ-027 Timeout: if the timeout counter reaches TIMEOUT_CYC without phys_valid, set fault and enter IDLE; phys_valid arriving in that same cycle takes priority and no fault is raised.
REQ-028 FREEZE: decrement the freeze counter on each tick; on the tick that makes it 0, enter RUN.
REQ-029 The first phys_en after FREEZE clears game_over inside the physics engine; the controller SHALL NOT count a second point from it, because it only scores on phys_valid.
REQ-030 MATCH_END: hold scores and match_winner; on a start edge, clear scores and match_winner, then enter RUN.
REQ-031 A start edge in RUN, WAIT_VALID or FREEZE SHALL be ignored.
REQ-032 phys_valid outside WAIT_VALID SHALL be ignored.
REQ-033 play_active = 1 exactly when state is RUN or WAIT_VALID.
REQ-034 All outputs SHALL be registered; state_o reflects the current state register.

Reset
REQ-035 Reset values: state IDLE, phys_en 0, play_active 0, scores 0, match_winner 0, fault 0, tick counter 0, freeze counter 0, timeout counter 0.
REQ-036 Reset asserted mid-frame or mid-freeze SHALL abort immediately to these values; no phys_en pulse is emitted after reset is released until a new start edge is seen.

Verification (TICK_DIV=10, WIN_SCORE=3, FREEZE_FRAMES=2, TIMEOUT_CYC=8)
REQ-037 Start edge; physics model returns phys_valid 3 cycles after each phys_en -> phys_en pulses spaced exactly 10 cycles apart, each one cycle wide; state sequence RUN->WAIT_VALID->RUN.
REQ-038 phys_valid with game_over=1, winner=2 -> score_p2=1, state FREEZE, no phys_en for 2 ticks, then phys_en on the 3rd tick; a following phys_valid with game_over=0 leaves score_p2=1.
REQ-039 Three P1 points -> score_p1=3, match_winner=1, state MATCH_END, phys_en stays 0; start edge -> scores 0, state RUN.
REQ-040 phys_en issued with no phys_valid returned -> fault=1 and state IDLE 8 cycles after entering WAIT_VALID; a second case with phys_valid in the 8th cycle gives no fault.
REQ-041 game_over=1 with winner=3 -> scores unchanged, back to RUN; start_btn held high through reset -> stays IDLE until the button is released and pressed again.
REQ-042 Reset asserted during FREEZE with score_p1=2 -> all outputs return to reset values asynchronously; no phys_en is seen afterwards until a new start edge.

Source files
------------

// File: rtl/match_ctrl.sv
// match_ctrl: sequences frame ticks, physics handshakes, scoring, post-point freeze and match end.
// A free-running tick divider paces phys_en launches; phys_valid results drive scoring.
module match_ctrl #(
    parameter int TICK_DIV      = 416667,
    parameter int WIN_SCORE     = 15,
    parameter int FREEZE_FRAMES = 90,
    parameter int TIMEOUT_CYC   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn_i,
    input  logic       phys_valid_i,
    input  logic       phys_game_over_i,
    input  logic [1:0] phys_winner_i,
    output logic       phys_en_o,
    output logic       play_active_o,
    output logic [3:0] score_p1_o,
    output logic [3:0] score_p2_o,
    output logic [1:0] match_winner_o,
    output logic [2:0] state_o,
    output logic       fault_o
);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        WAIT_VALID = 3'd2,
        FREEZE     = 3'd3,
        MATCH_END  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [7:0]    frz_q, frz_d, tmo_q, tmo_d;
    logic [3:0]    p1_q, p1_d, p2_q, p2_d, new_p1, new_p2;
    logic [1:0]    win_q, win_d;
    logic          btn_q, en_q, en_d, act_q, fault_q, fault_d;
    logic          tick, start, point, reach;

    assign tick   = cnt_q == CW'(TICK_DIV - 1);
    assign start  = start_btn_i & ~btn_q;
    assign new_p1 = p1_q + 4'd1;
    assign new_p2 = p2_q + 4'd1;
    // Only winners 1 and 2 score; codes 0 and 3 are treated as a no-point frame.
    assign point  = phys_game_over_i & (phys_winner_i[0] ^ phys_winner_i[1]);
    assign reach  = (phys_winner_i[0] ? new_p1 : new_p2) == 4'(WIN_SCORE);

    always_comb begin
        state_d = state_q;
        frz_d   = frz_q;
        tmo_d   = tmo_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        win_d   = win_q;
        fault_d = fault_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE, MATCH_END: if (start) begin
                p1_d    = '0;
                p2_d    = '0;
                win_d   = '0;
                fault_d = 1'b0;
                state_d = RUN;
            end
            RUN: if (tick) begin
                en_d    = 1'b1;
                tmo_d   = '0;
                state_d = WAIT_VALID;
            end
            WAIT_VALID: if (phys_valid_i) begin
                if (point) begin
                    p1_d    = phys_winner_i[0] ? new_p1 : p1_q;
                    p2_d    = phys_winner_i[1] ? new_p2 : p2_q;
                    win_d   = reach ? phys_winner_i : win_q;
                    frz_d   = reach ? frz_q : 8'(FREEZE_FRAMES);
                    state_d = reach ? MATCH_END : FREEZE;
                end else begin
                    state_d = RUN;
                end
            end else if (tmo_q == 8'(TIMEOUT_CYC - 1)) begin
                fault_d = 1'b1;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
            FREEZE: if (tick) begin
                frz_d   = frz_q - 8'd1;
                state_d = frz_q == 8'd1 ? RUN : FREEZE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frz_q   <= '0;
            tmo_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= '0;
            btn_q   <= 1'b1;
            en_q    <= 1'b0;
            act_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            frz_q   <= frz_d;
            tmo_q   <= tmo_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            win_q   <= win_d;
            btn_q   <= start_btn_i;
            en_q    <= en_d;
            act_q   <= state_d == RUN || state_d == WAIT_VALID;
            fault_q <= fault_d;
        end
    end

    assign phys_en_o      = en_q;
    assign play_active_o  = act_q;
    assign score_p1_o     = p1_q;
    assign score_p2_o     = p2_q;
    assign match_winner_o = win_q;
    assign state_o        = state_q;
    assign fault_o        = fault_q;
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed and randomized checks of match_ctrl against a frame-level model
// where launches fall on multiples of TICK_DIV cycles after reset release.
module tb_match_ctrl;
    localparam int TD = 10, WIN = 3, FRZF = 2, TMO = 8;
    localparam int IDLE = 0, RUN = 1, WAIT = 2, FRZ = 3, MEND = 4;

    logic       clk = 0, rst_n = 0, start_btn_i = 0, phys_valid_i = 0, phys_game_over_i = 0;
    logic [1:0] phys_winner_i = 0;
    logic       phys_en_o, play_active_o, fault_o;
    logic [3:0] score_p1_o, score_p2_o;
    logic [1:0] match_winner_o;
    logic [2:0] state_o;
    int vectors = 0, miscompares = 0;
    int cyc, s1, s2, mw, xs, nxt;

    match_ctrl #(.TICK_DIV(TD), .WIN_SCORE(WIN), .FREEZE_FRAMES(FRZF), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start_btn_i(start_btn_i), .phys_valid_i(phys_valid_i),
        .phys_game_over_i(phys_game_over_i), .phys_winner_i(phys_winner_i), .phys_en_o(phys_en_o),
        .play_active_o(play_active_o), .score_p1_o(score_p1_o), .score_p2_o(score_p2_o),
        .match_winner_o(match_winner_o), .state_o(state_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges since reset release.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ceil10(input int c);
        return (c / TD + 1) * TD;
    endfunction

    task automatic rst_chk(input string tag);
        chk({tag, "_state"}, state_o, IDLE);
        chk({tag, "_en"}, phys_en_o, 0);
        chk({tag, "_play"}, play_active_o, 0);
        chk({tag, "_p1"}, score_p1_o, 0);
        chk({tag, "_p2"}, score_p2_o, 0);
        chk({tag, "_winner"}, match_winner_o, 0);
        chk({tag, "_fault"}, fault_o, 0);
    endtask

    task automatic press();
        start_btn_i = 0;
        step();
        start_btn_i = 1;
        step();
        start_btn_i = 0;
        s1 = 0; s2 = 0; mw = 0; xs = RUN;
        nxt = ceil10(cyc);
        chk("press_state", state_o, RUN);
        chk("press_p1", score_p1_o, 0);
        chk("press_p2", score_p2_o, 0);
        chk("press_winner", match_winner_o, 0);
        chk("press_fault", fault_o, 0);
        chk("press_play", play_active_o, 1);
    endtask

    // Idle-type wait with stray phys_valid pulses that must be ignored.
    task automatic hold(input int n);
        int ens = 0;
        for (int k = 0; k < n; k++) begin
            phys_valid_i = 1'($urandom_range(0, 1));
            phys_game_over_i = 1;
            phys_winner_i = 2'($urandom_range(1, 2));
            step();
            ens += int'(phys_en_o);
        end
        phys_valid_i = 0; phys_game_over_i = 0; phys_winner_i = 0;
        chk("hold_en", ens, 0);
        chk("hold_state", state_o, xs);
        chk("hold_p1", score_p1_o, s1);
        chk("hold_p2", score_p2_o, s2);
        chk("hold_winner", match_winner_o, mw);
    endtask

    // Waits for phys_en while injecting ignored start presses and stray phys_valid.
    task automatic wait_en();
        for (int k = 0; k < 200; k++) begin
            step();
            if (phys_en_o) break;
            phys_valid_i = 1'($urandom_range(0, 1));
            phys_game_over_i = 1;
            phys_winner_i = 2'($urandom_range(1, 2));
            start_btn_i = 1'($urandom_range(0, 1));
        end
        phys_valid_i = 0; phys_game_over_i = 0; phys_winner_i = 0; start_btn_i = 0;
    endtask

    task automatic frame(input int d, input bit go, input logic [1:0] w, input bit to);
        wait_en();
        chk("en_cycle", cyc, nxt);
        chk("en_pulse", phys_en_o, 1);
        chk("en_state", state_o, WAIT);
        chk("en_play", play_active_o, 1);
        if (to) begin
            repeat (TMO - 1) step();
            chk("to_pre_state", state_o, WAIT);
            chk("to_pre_fault", fault_o, 0);
            step();
            xs = IDLE;
            chk("to_state", state_o, IDLE);
            chk("to_fault", fault_o, 1);
            chk("to_play", play_active_o, 0);
            return;
        end
        for (int j = 0; j < d; j++) begin
            step();
            if (j == 0) chk("en_width", phys_en_o, 0);
        end
        phys_valid_i = 1; phys_game_over_i = go; phys_winner_i = w;
        step();
        phys_valid_i = 0; phys_game_over_i = 0; phys_winner_i = 0;
        if (go && (w == 1 || w == 2)) begin
            if (w == 1) s1++; else s2++;
            if (s1 == WIN || s2 == WIN) begin
                xs = MEND; mw = int'(w);
            end else begin
                xs = FRZ; nxt = ceil10(cyc) + TD * FRZF;
            end
        end else begin
            xs = RUN; nxt = ceil10(cyc);
        end
        chk("rsp_state", state_o, xs);
        chk("rsp_p1", score_p1_o, s1);
        chk("rsp_p2", score_p2_o, s2);
        chk("rsp_winner", match_winner_o, mw);
        chk("rsp_fault", fault_o, 0);
        chk("rsp_play", play_active_o, xs == RUN);
        chk("rsp_en", phys_en_o, 0);
    endtask

    initial begin
        bit to;
        start_btn_i = 1;
        #12;
        rst_chk("rst");
        @(negedge clk);
        rst_n = 1;
        xs = IDLE; s1 = 0; s2 = 0; mw = 0;
        hold(20);
        press();
        frame(3, 0, 0, 0);
        frame(3, 0, 0, 0);
        frame(3, 1, 2, 0);
        frame(3, 0, 0, 0);
        frame(2, 1, 3, 0);
        frame(5, 1, 0, 0);
        frame(7, 0, 0, 0);
        frame(0, 0, 0, 1);
        press();
        frame(1, 1, 1, 0);
        frame(1, 1, 1, 0);
        frame(1, 1, 1, 0);
        hold(40);
        press();
        frame(1, 1, 1, 0);
        frame(4, 1, 1, 0);
        step();
        step();
        #3 rst_n = 0;
        #1 rst_chk("frz_rst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        xs = IDLE; s1 = 0; s2 = 0; mw = 0;
        hold(40);
        press();
        for (int i = 0; i < 80; i++) begin
            to = $urandom_range(0, 9) == 0;
            frame($urandom_range(0, 7), $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), to);
            if (to) begin
                press();
            end else if (xs == MEND) begin
                hold($urandom_range(5, 30));
                press();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
